din_debouncer: RTL and testbench

Input-conditioning stage that sits directly upstream of the asynchronous-reset D flip-flop. It takes a raw, possibly bouncing or asynchronous one-bit signal and produces a clean, debounced level for the flop's D input. It also produces single-cycle rise and fall strobes. A level change is accepted only after the input has held steady for a programmable number of clock cycles.

---
 rtl/din_debouncer_pkg.sv | 18 +
 rtl/sync_2ff.sv | 25 ++
 rtl/din_debouncer.sv | 125 ++++++++++++
 tb/tb_din_debouncer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/din_debouncer_pkg.sv
// Shared types and constants for the din_debouncer input-conditioning block.
package din_debouncer_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'b00,
        S_RISE_WAIT = 2'b01,
        S_HIGH      = 2'b10,
        S_FALL_WAIT = 2'b11
    } state_t;

    localparam int STABLE_CYCLES_MIN = 2;

    // Wait states are exactly the encodings with bit 0 set.
    function automatic logic is_wait_state(input state_t st);
        return st[0];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/din_debouncer.sv
// Debounces a raw one-bit input into a clean level plus rise/fall strobes.
// Optional input synchronizer enabled by defining DIN_DEBOUNCER_SYNC_EN.
module din_debouncer
    import din_debouncer_pkg::*;
#(
    parameter  int STABLE_CYCLES = 4,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic q,
    output logic not_q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             w_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_q;
    logic             w_q_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             r_busy;

`ifdef DIN_DEBOUNCER_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (d_in),
        .q     (w_s)
    );
`else
    assign w_s = d_in;
`endif

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_LOW;
            r_cnt   <= CNT_ZERO;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= is_wait_state(w_state_nxt);
        end
    end

    // Next-state: any return to the old level drops the candidate outright.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = CNT_ZERO;
        w_q_nxt     = r_q;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            S_LOW: begin
                if (w_s) begin
                    w_state_nxt = S_RISE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_state_nxt = S_LOW;
                end
            end
            S_RISE_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = S_LOW;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_HIGH;
                    w_q_nxt     = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = S_FALL_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_state_nxt = S_HIGH;
                end
            end
            S_FALL_WAIT: begin
                if (w_s) begin
                    w_state_nxt = S_HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_LOW;
                    w_q_nxt     = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_LOW;
                w_q_nxt     = 1'b0;
            end
        endcase
    end

    assign q     = r_q;
    assign not_q = ~r_q;
    assign rise  = r_rise;
    assign fall  = r_fall;
    assign busy  = r_busy;

endmodule

// File: tb/tb_din_debouncer.sv
// Self-checking bench for din_debouncer: run-length reference model plus directed checks.
module tb_din_debouncer;

    localparam int SC = 4;
`ifdef DIN_DEBOUNCER_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic d_in  = 1'b0;
    logic q, not_q, rise, fall, busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    din_debouncer #(.STABLE_CYCLES(SC)) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .q     (q),
        .not_q (not_q),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference model: q flips once SC consecutive samples disagree with it.
    logic m_q, m_rise, m_fall, m_s1, m_s2, m_s;
    int   m_run;
`ifdef DIN_DEBOUNCER_SYNC_EN
    assign m_s = m_s2;
`else
    assign m_s = d_in;
`endif

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0;
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_run <= 0;
        end else begin
            m_s1 <= d_in;
            m_s2 <= m_s1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_s != m_q) begin
                if (m_run + 1 == SC) begin
                    m_q <= m_s; m_run <= 0;
                    m_rise <= m_s; m_fall <= ~m_s;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    task automatic check(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_q", q, m_q);
            check("mdl_not_q", not_q, ~m_q);
            check("mdl_rise", rise, m_rise);
            check("mdl_fall", fall, m_fall);
            check("mdl_busy", busy, (m_run != 0));
            check("rise_fall_excl", rise & fall, 1'b0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;

        // Reset held with d_in toggling.
        for (int i = 0; i < 3; i++) begin
            d_in = ~d_in;
            tick(1);
            check("rst_q", q, 1'b0);
            check("rst_not_q", not_q, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_rise", rise, 1'b0);
        end

        // Clean rise.
        d_in = 1'b1; reset = 1'b1;
        for (int i = 1; i <= 3 + EXTRA; i++) begin
            tick(1);
            check("rise_busy", busy, (i > EXTRA));
            check("rise_q_lo", q, 1'b0);
        end
        tick(1);
        check("rise_q", q, 1'b1);
        check("rise_pulse", rise, 1'b1);
        check("rise_not_q", not_q, 1'b0);
        tick(1);
        check("rise_pulse_end", rise, 1'b0);

        // Clean fall.
        d_in = 1'b0;
        for (int i = 1; i <= 3 + EXTRA; i++) begin
            tick(1);
            check("fall_q_hi", q, 1'b1);
            check("fall_no_pulse", fall, 1'b0);
        end
        tick(1);
        check("fall_q", q, 1'b0);
        check("fall_pulse", fall, 1'b1);
        check("fall_not_q", not_q, 1'b1);
        tick(1);
        check("fall_pulse_end", fall, 1'b0);

        // Glitch: 1,1,0 then steady 1.
        d_in = 1'b1; tick(2);
        d_in = 1'b0; tick(1);
        d_in = 1'b1;
        for (int i = 1; i <= 3 + EXTRA; i++) begin
            tick(1);
            check("glitch_q_lo", q, 1'b0);
            check("glitch_no_rise", rise, 1'b0);
        end
        tick(1);
        check("glitch_q", q, 1'b1);
        check("glitch_rise", rise, 1'b1);

        // Toggle every cycle: q must hold.
        for (int i = 0; i < 8; i++) begin
            d_in = ~d_in;
            tick(1);
            check("tog_q", q, 1'b1);
        end

        d_in = 1'b0;
        tick(SC + EXTRA + 1);
        check("settle_lo", q, 1'b0);

        // Reset during qualification.
        d_in = 1'b1;
        tick(3 + EXTRA);
        check("mid_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_q", q, 1'b0);
        tick(1);
        check("mid_rst_rise", rise, 1'b0);
        reset = 1'b1;
        for (int i = 1; i <= 3 + EXTRA; i++) begin
            tick(1);
            check("requal_q_lo", q, 1'b0);
        end
        tick(1);
        check("requal_q", q, 1'b1);
        check("requal_rise", rise, 1'b1);

        // Asynchronous reset from q=1 between edges.
        tick(2);
        check("pre_async_q", q, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_q", q, 1'b0);
        check("async_not_q", not_q, 1'b1);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
